video_out_stage: RTL and testbench

VIDEO_OUT_STAGE -- requirements
Module: video_out_stage

---
 rtl/video_out_stage_if.sv | 35 +++
 rtl/video_out_stage.sv | 133 +++++++++++++
 tb/tb_video_out_stage.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/video_out_stage_if.sv
// Pixel stream into the video output stage and the normalised stream plus measured geometry out.
interface video_out_stage_if #(
  parameter int CNT_W = 12
);
  logic             ce_pix;
  logic [7:0]       r_in;
  logic [7:0]       g_in;
  logic [7:0]       b_in;
  logic             hblank_in;
  logic             vblank_in;
  logic             hs_in;
  logic             vs_in;
  logic [7:0]       r_out;
  logic [7:0]       g_out;
  logic [7:0]       b_out;
  logic             hs_out;
  logic             vs_out;
  logic             de_out;
  logic             ce_out;
  logic [CNT_W-1:0] active_w;
  logic [CNT_W-1:0] active_h;
  logic             timing_valid;

  modport master (
    output ce_pix, r_in, g_in, b_in, hblank_in, vblank_in, hs_in, vs_in,
    input  r_out, g_out, b_out, hs_out, vs_out, de_out, ce_out,
           active_w, active_h, timing_valid
  );

  modport slave (
    input  ce_pix, r_in, g_in, b_in, hblank_in, vblank_in, hs_in, vs_in,
    output r_out, g_out, b_out, hs_out, vs_out, de_out, ce_out,
           active_w, active_h, timing_valid
  );
endinterface

// File: rtl/video_out_stage.sv
// Video output stage: 2-strobe pipeline, blank forcing, sync polarity normalisation, geometry measurement.
// Latency 2 ce_pix strobes; no backpressure, everything advances only on ce_pix.
module video_out_stage #(
  parameter int CNT_W  = 12,
  parameter int VCNT_W = 10
) (
  input  logic             clk_vid,
  input  logic             reset,
  video_out_stage_if.slave vid
);

  logic [7:0]        s1_r, s1_g, s1_b;
  logic [7:0]        s2_r, s2_g, s2_b;
  logic              s1_hs, s1_vs, s1_de, s1_vb;
  logic              s2_hs, s2_vs, s2_de;
  logic              hs_inv, vs_inv;
  logic [CNT_W-1:0]  hs_hi_len, hs_lo_len;
  logic [VCNT_W-1:0] vs_hi_len, vs_lo_len;
  logic [CNT_W-1:0]  pix_cnt, line_cnt, frame_w;
  logic [CNT_W-1:0]  active_w, active_h;
  logic              armed, timing_valid, ce_out;

  logic              de1, hs_rise, hs_fall, vs_rise, vs_fall, de_fall, frame_edge;
  logic [CNT_W-1:0]  frame_w_end, line_cnt_end;

  function automatic logic [CNT_W-1:0] inc_c(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [VCNT_W-1:0] inc_v(input logic [VCNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Edges compare the sample being captured against the stage-1 copy of the previous one.
  always_comb begin
    de1          = ~(vid.hblank_in | vid.vblank_in);
    hs_rise      = vid.hs_in & ~s1_hs;
    hs_fall      = ~vid.hs_in & s1_hs;
    vs_rise      = vid.vs_in & ~s1_vs;
    vs_fall      = ~vid.vs_in & s1_vs;
    de_fall      = ~de1 & s1_de;
    frame_edge   = vid.vblank_in & ~s1_vb;
    frame_w_end  = (de_fall && (pix_cnt > frame_w)) ? pix_cnt : frame_w;
    line_cnt_end = de_fall ? inc_c(line_cnt) : line_cnt;
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      s1_r <= '0; s1_g <= '0; s1_b <= '0;
      s2_r <= '0; s2_g <= '0; s2_b <= '0;
      s1_hs <= 1'b0; s1_vs <= 1'b0; s1_de <= 1'b0; s1_vb <= 1'b0;
      s2_hs <= 1'b0; s2_vs <= 1'b0; s2_de <= 1'b0;
      hs_inv <= 1'b0; vs_inv <= 1'b0;
      hs_hi_len <= '0; hs_lo_len <= '0;
      vs_hi_len <= '0; vs_lo_len <= '0;
      pix_cnt <= '0; line_cnt <= '0; frame_w <= '0;
      active_w <= '0; active_h <= '0;
      armed <= 1'b0; timing_valid <= 1'b0; ce_out <= 1'b0;
    end else begin
      ce_out <= vid.ce_pix;
      if (vid.ce_pix) begin
        s1_r  <= vid.r_in;
        s1_g  <= vid.g_in;
        s1_b  <= vid.b_in;
        s1_hs <= vid.hs_in;
        s1_vs <= vid.vs_in;
        s1_de <= de1;
        s1_vb <= vid.vblank_in;
        s2_r  <= s1_de ? s1_r : 8'h00;
        s2_g  <= s1_de ? s1_g : 8'h00;
        s2_b  <= s1_de ? s1_b : 8'h00;
        s2_hs <= s1_hs;
        s2_vs <= s1_vs;
        s2_de <= s1_de;

        // A sync whose high phase outlasts its low phase is active-low.
        if (hs_rise) begin
          hs_inv    <= hs_hi_len > hs_lo_len;
          hs_hi_len <= CNT_W'(1);
        end else if (hs_fall) begin
          hs_lo_len <= CNT_W'(1);
        end else if (vid.hs_in) begin
          hs_hi_len <= inc_c(hs_hi_len);
        end else begin
          hs_lo_len <= inc_c(hs_lo_len);
        end

        if (vs_rise) begin
          vs_inv    <= vs_hi_len > vs_lo_len;
          vs_hi_len <= hs_rise ? VCNT_W'(1) : '0;
        end else if (vs_fall) begin
          vs_lo_len <= hs_rise ? VCNT_W'(1) : '0;
        end else if (hs_rise) begin
          if (vid.vs_in) vs_hi_len <= inc_v(vs_hi_len);
          else           vs_lo_len <= inc_v(vs_lo_len);
        end

        if (de1)          pix_cnt <= inc_c(pix_cnt);
        else if (de_fall) pix_cnt <= '0;

        if (frame_edge) begin
          armed <= 1'b1;
          if (armed) begin
            active_w <= frame_w_end;
            active_h <= line_cnt_end;
            if ((frame_w_end == active_w) && (line_cnt_end == active_h)) begin
              if ((frame_w_end != '0) && (line_cnt_end != '0)) timing_valid <= 1'b1;
            end else begin
              timing_valid <= 1'b0;
            end
          end
          frame_w  <= '0;
          line_cnt <= '0;
        end else begin
          frame_w  <= frame_w_end;
          line_cnt <= line_cnt_end;
        end
      end
    end
  end

  assign vid.r_out        = s2_r;
  assign vid.g_out        = s2_g;
  assign vid.b_out        = s2_b;
  assign vid.hs_out       = s2_hs ^ hs_inv;
  assign vid.vs_out       = s2_vs ^ vs_inv;
  assign vid.de_out       = s2_de;
  assign vid.ce_out       = ce_out;
  assign vid.active_w     = active_w;
  assign vid.active_h     = active_h;
  assign vid.timing_valid = timing_valid;

endmodule

// File: tb/tb_video_out_stage.sv
// Bench for video_out_stage: directed video patterns, a period/queue based reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_video_out_stage;

  localparam int CMAX = 4095;
  localparam int VMAX = 1023;

  logic clk_vid = 1'b0;
  logic reset;
  always #5 clk_vid = ~clk_vid;

  video_out_stage_if #(.CNT_W(12)) vif ();

  video_out_stage #(.CNT_W(12), .VCNT_W(10)) dut (
    .clk_vid (clk_vid),
    .reset   (reset),
    .vid     (vif)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic chk_en = 1'b0;
  int hs_hi_tot = 0;
  int vs_hi_tot = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of samples for the pipeline, run lengths for sync
  // periods, list of completed line widths for the frame geometry.
  typedef struct packed {
    logic [7:0] r, g, b;
    logic       hs, vs, de;
  } pix_t;

  pix_t hist[$];
  int   widths[$];
  int   h_run, h_hi_done, v_run, v_hi_done, de_run;
  logic h_inv, v_inv, p_hs, p_vs, p_de, p_vb, m_armed;
  logic [7:0] e_r, e_g, e_b;
  logic e_hs, e_vs, e_de, e_ce, e_tv;
  int   e_w, e_h;

  always @(posedge clk_vid) begin : model
    pix_t s, prev;
    logic hr;
    int   w, h;
    if (reset) begin
      hist.delete(); widths.delete();
      h_run = 0; h_hi_done = 0; v_run = 0; v_hi_done = 0; de_run = 0;
      h_inv = 0; v_inv = 0; p_hs = 0; p_vs = 0; p_de = 0; p_vb = 0; m_armed = 0;
      e_r = 0; e_g = 0; e_b = 0; e_hs = 0; e_vs = 0; e_de = 0; e_ce = 0;
      e_w = 0; e_h = 0; e_tv = 0;
    end else begin
      e_ce = vif.ce_pix;
      if (vif.ce_pix) begin
        s.r  = vif.r_in; s.g = vif.g_in; s.b = vif.b_in;
        s.hs = vif.hs_in; s.vs = vif.vs_in;
        s.de = !(vif.hblank_in || vif.vblank_in);
        hr   = s.hs && !p_hs;

        if (s.hs != p_hs) begin
          if (s.hs) h_inv = (h_hi_done > h_run);
          else      h_hi_done = h_run;
          h_run = 1;
        end else begin
          h_run = (h_run < CMAX) ? h_run + 1 : CMAX;
        end

        if (s.vs != p_vs) begin
          if (s.vs) v_inv = (v_hi_done > v_run);
          else      v_hi_done = v_run;
          v_run = hr ? 1 : 0;
        end else if (hr) begin
          v_run = (v_run < VMAX) ? v_run + 1 : VMAX;
        end

        hist.push_front(s);
        if (hist.size() > 2) void'(hist.pop_back());
        prev = (hist.size() > 1) ? hist[1] : '0;
        e_r  = prev.de ? prev.r : 8'h00;
        e_g  = prev.de ? prev.g : 8'h00;
        e_b  = prev.de ? prev.b : 8'h00;
        e_hs = prev.hs ^ h_inv;
        e_vs = prev.vs ^ v_inv;
        e_de = prev.de;

        if (s.de) begin
          de_run++;
        end else if (p_de) begin
          widths.push_back((de_run > CMAX) ? CMAX : de_run);
          de_run = 0;
        end
        if (vif.vblank_in && !p_vb) begin
          if (m_armed) begin
            w = 0;
            foreach (widths[i]) if (widths[i] > w) w = widths[i];
            h = (widths.size() > CMAX) ? CMAX : widths.size();
            if (w == e_w && h == e_h) begin
              if (w != 0 && h != 0) e_tv = 1'b1;
            end else begin
              e_tv = 1'b0;
            end
            e_w = w;
            e_h = h;
          end
          m_armed = 1'b1;
          widths.delete();
        end
        p_hs = s.hs; p_vs = s.vs; p_de = s.de; p_vb = vif.vblank_in;
      end
    end
  end

  always @(negedge clk_vid) begin
    if (chk_en) begin
      check("pix", 64'({vif.r_out, vif.g_out, vif.b_out, vif.hs_out, vif.vs_out, vif.de_out}),
            64'({e_r, e_g, e_b, e_hs, e_vs, e_de}));
      check("ce_out", 64'(vif.ce_out), 64'(e_ce));
      check("geom", 64'({vif.active_w, vif.active_h, vif.timing_valid}),
            64'({e_w[11:0], e_h[11:0], e_tv}));
      if (vif.ce_out) begin
        if (vif.hs_out) hs_hi_tot++;
        if (vif.vs_out) vs_hi_tot++;
      end
    end
  end

  // One pixel: strobe cycle followed by an idle cycle (ce_pix every 2nd clock).
  task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic hb, input logic vb, input logic hs, input logic vs);
    vif.r_in = r; vif.g_in = g; vif.b_in = b;
    vif.hblank_in = hb; vif.vblank_in = vb; vif.hs_in = hs; vif.vs_in = vs;
    vif.ce_pix = 1'b1;
    @(posedge clk_vid); #1;
    vif.ce_pix = 1'b0;
    @(posedge clk_vid); #1;
  endtask

  task automatic do_reset(input int n);
    vif.ce_pix = 1'b0;
    reset = 1'b1;
    repeat (n) @(posedge clk_vid);
    #1 reset = 1'b0;
  endtask

  // w active pixels per line, h lines, last line runs straight into vblank.
  task automatic frame(input int w, input int h);
    for (int l = 0; l < h; l++) begin
      for (int p = 0; p < w; p++) pix(8'(p), 8'(l), 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
      if (l != h - 1)
        for (int p = 0; p < 6; p++) pix(8'h77, 8'h77, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    for (int p = 0; p < 8; p++) pix(8'h11, 8'h22, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic hs_lines(input int first_len, input logic first_lvl, input int second_len,
                          output int line3_hi);
    int snap;
    snap = 0;
    for (int l = 0; l < 3; l++) begin
      if (l == 2) snap = hs_hi_tot;
      for (int p = 0; p < first_len; p++)
        pix(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, first_lvl, 1'b0);
      for (int p = 0; p < second_len; p++)
        pix(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, !first_lvl, 1'b0);
    end
    line3_hi = hs_hi_tot - snap;
  endtask

  initial begin
    int cnt, snap;
    reset = 1'b1;
    vif.ce_pix = 1'b0;
    vif.r_in = '0; vif.g_in = '0; vif.b_in = '0;
    vif.hblank_in = 1'b0; vif.vblank_in = 1'b0; vif.hs_in = 1'b0; vif.vs_in = 1'b0;
    @(posedge clk_vid); #1 chk_en = 1'b1;
    do_reset(3);
    check("rst_state", 64'({vif.r_out, vif.g_out, vif.b_out, vif.hs_out, vif.vs_out, vif.de_out,
                            vif.ce_out, vif.active_w, vif.active_h, vif.timing_valid}), 64'h0);

    // Latency and blank forcing
    repeat (3) pix(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    pix(8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lat_early", 64'(vif.r_out), 64'h0);
    pix(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lat_r", 64'(vif.r_out), 64'hFF);
    check("lat_de", 64'(vif.de_out), 64'h1);
    repeat (2) pix(8'h55, 8'h55, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    check("blank_rgb", 64'({vif.r_out, vif.g_out, vif.b_out}), 64'h0);
    check("blank_de", 64'(vif.de_out), 64'h0);

    // HS polarity: negative then positive sync
    do_reset(2);
    hs_lines(64, 1'b0, 846, cnt);
    check("hs_neg_hi", 64'(cnt), 64'd64);
    do_reset(2);
    hs_lines(64, 1'b1, 846, cnt);
    check("hs_pos_hi", 64'(cnt), 64'd64);

    // VS polarity: short lines, vs low 2 lines / high 10 lines
    do_reset(2);
    snap = 0;
    for (int f = 0; f < 3; f++) begin
      if (f == 2) snap = vs_hi_tot;
      for (int l = 0; l < 12; l++)
        for (int p = 0; p < 8; p++)
          pix(8'h10, 8'h20, 8'h30, 1'b0, 1'b0, (p < 4), (l >= 2));
    end
    check("vs_neg_hi", 64'(vs_hi_tot - snap), 64'd16);

    // Geometry
    do_reset(2);
    frame(40, 6);
    check("geom_f1", 64'({vif.active_w, vif.active_h, vif.timing_valid}), 64'h0);
    frame(40, 6);
    check("geom_f2", 64'({vif.active_w, vif.active_h, vif.timing_valid}), 64'({12'd40, 12'd6, 1'b0}));
    frame(40, 6);
    check("geom_f3", 64'({vif.active_w, vif.active_h, vif.timing_valid}), 64'({12'd40, 12'd6, 1'b1}));
    frame(35, 6);
    check("geom_f4", 64'({vif.active_w, vif.active_h, vif.timing_valid}), 64'({12'd35, 12'd6, 1'b0}));

    // Reset mid-line
    repeat (10) pix(8'hAA, 8'hBB, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0);
    vif.ce_pix = 1'b1;
    reset = 1'b1;
    @(posedge clk_vid); #1;
    reset = 1'b0;
    vif.ce_pix = 1'b0;
    check("rst_mid", 64'({vif.r_out, vif.g_out, vif.b_out, vif.hs_out, vif.vs_out, vif.de_out,
                          vif.ce_out, vif.active_w, vif.active_h, vif.timing_valid}), 64'h0);
    repeat (20) pix(8'hAA, 8'hBB, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rst_aw", 64'(vif.active_w), 64'h0);
    frame(12, 3);
    check("geom_post_rst", 64'({vif.active_w, vif.active_h, vif.timing_valid}), 64'({12'd12, 12'd3, 1'b0}));

    // Pixel counter saturation
    do_reset(2);
    frame(5, 1);
    frame(4200, 1);
    check("sat_w", 64'({vif.active_w, vif.active_h}), 64'({12'd4095, 12'd1}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
